// File: rtl/npc_rf_pkg.sv
// Shared register-file constants and the write-request record used by the
// GPR file, the EXU/LSU writeback paths and the writeback arbiter.
package npc_rf_pkg;

  localparam int NUM_REGS   = 32;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;

  // Writes to x0 are architecturally discarded.
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding slot. Accepts a request whenever it is empty
// or its current entry is being granted this cycle, so a steady stream
// drains at one write per cycle. Requests to x0 are consumed but never held.
module rf_wb_slot
  import npc_rf_pkg::*;
#(
  parameter int ADDR_WIDTH_P = npc_rf_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH_P = npc_rf_pkg::DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic [ADDR_WIDTH_P-1:0] i_waddr,
  input  logic [DATA_WIDTH_P-1:0] i_wdata,
  input  logic                    i_grant,
  output logic                    o_ready,
  output logic                    o_load,
  output logic                    o_valid,
  output logic [ADDR_WIDTH_P-1:0] o_waddr,
  output logic [DATA_WIDTH_P-1:0] o_wdata
);

  logic                    r_valid;
  logic [ADDR_WIDTH_P-1:0] r_waddr;
  logic [DATA_WIDTH_P-1:0] r_wdata;
  logic                    w_accept;

  assign o_ready  = ~r_valid | i_grant;
  assign w_accept = i_valid & o_ready;
  // An accepted x0 write is simply dropped here.
  assign o_load   = w_accept & (i_waddr != ADDR_WIDTH_P'(REG_ZERO));

  assign o_valid  = r_valid;
  assign o_waddr  = r_waddr;
  assign o_wdata  = r_wdata;

  // Slot contents: a load wins over the clear caused by a grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (o_load) begin
      r_valid <= 1'b1;
      r_waddr <= i_waddr;
      r_wdata <= i_wdata;
    end else if (i_grant) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single GPR write port. Port 0 is the EXU, port 1
// the LSU. Same-destination writes issue oldest first; otherwise contested
// cycles alternate between the ports. Exposes a pending bitmap for decode.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = npc_rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = npc_rf_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = npc_rf_pkg::NUM_REGS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_s0_valid,
  output logic                  o_s0_ready,
  input  logic [ADDR_WIDTH-1:0] i_s0_waddr,
  input  logic [DATA_WIDTH-1:0] i_s0_wdata,
  input  logic                  i_s1_valid,
  output logic                  o_s1_ready,
  input  logic [ADDR_WIDTH-1:0] i_s1_waddr,
  input  logic [DATA_WIDTH-1:0] i_s1_wdata,
  output logic                  o_rf_wen,
  output logic [ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  output logic [NUM_REGS-1:0]   o_pending
);

  logic                  w_v0, w_v1;
  logic [ADDR_WIDTH-1:0] w_a0, w_a1;
  logic [DATA_WIDTH-1:0] w_d0, w_d1;
  logic                  w_load0, w_load1;
  logic                  w_grant0, w_grant1;
  logic                  w_sel;        // granted slot index
  logic                  w_contested;
  logic                  w_same_addr;
  logic                  w_keep0, w_keep1;
  logic                  r_age;        // 1: slot 1 holds the older entry
  logic                  r_rr;         // port favoured on the next contest

  rf_wb_slot #(.ADDR_WIDTH_P(ADDR_WIDTH), .DATA_WIDTH_P(DATA_WIDTH)) u_slot0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_s0_valid),
    .i_waddr (i_s0_waddr),
    .i_wdata (i_s0_wdata),
    .i_grant (w_grant0),
    .o_ready (o_s0_ready),
    .o_load  (w_load0),
    .o_valid (w_v0),
    .o_waddr (w_a0),
    .o_wdata (w_d0)
  );

  rf_wb_slot #(.ADDR_WIDTH_P(ADDR_WIDTH), .DATA_WIDTH_P(DATA_WIDTH)) u_slot1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_s1_valid),
    .i_waddr (i_s1_waddr),
    .i_wdata (i_s1_wdata),
    .i_grant (w_grant1),
    .o_ready (o_s1_ready),
    .o_load  (w_load1),
    .o_valid (w_v1),
    .o_waddr (w_a1),
    .o_wdata (w_d1)
  );

  assign w_contested = w_v0 & w_v1;
  assign w_same_addr = (w_a0 == w_a1);

  // Grant selection: age decides same-address conflicts, rr_ptr the rest.
  always_comb begin
    w_sel = w_v1;
    if (w_contested) begin
      w_sel = w_same_addr ? r_age : r_rr;
    end
  end

  assign o_rf_wen   = w_v0 | w_v1;
  assign w_grant0   = o_rf_wen & ~w_sel;
  assign w_grant1   = o_rf_wen & w_sel;
  assign o_rf_waddr = o_rf_wen ? (w_sel ? w_a1 : w_a0) : '0;
  assign o_rf_wdata = o_rf_wen ? (w_sel ? w_d1 : w_d0) : '0;

  // A slot keeps its current entry when it is valid and not granted.
  assign w_keep0 = w_v0 & ~w_grant0 & ~w_load0;
  assign w_keep1 = w_v1 & ~w_grant1 & ~w_load1;

  // Round-robin pointer moves only after a different-address contest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr <= 1'b0;
    end else if (w_contested && !w_same_addr) begin
      r_rr <= ~w_sel;
    end
  end

  // Age bit: a newly loaded entry is younger than one already held; on a
  // simultaneous load the LSU entry is treated as older.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_age <= 1'b0;
    end else if (w_load0 && w_load1) begin
      r_age <= 1'b1;
    end else if (w_load0 && w_keep1) begin
      r_age <= 1'b1;
    end else if (w_load1 && w_keep0) begin
      r_age <= 1'b0;
    end
  end

  // Pending decoder; x0 can never be pending.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : gen_pending
      if (gi == 0) begin : gen_zero
        assign o_pending[gi] = 1'b0;
      end else begin : gen_reg
        assign o_pending[gi] = (w_v0 & (w_a0 == ADDR_WIDTH'(gi))) |
                               (w_v1 & (w_a1 == ADDR_WIDTH'(gi)));
      end
    end
  endgenerate

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for the writeback arbiter: directed scenarios plus a randomized
// stream, all checked every cycle against a queue/timestamp model.
module tb_rf_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_s0_valid, i_s1_valid;
  logic        o_s0_ready, o_s1_ready;
  logic [4:0]  i_s0_waddr, i_s1_waddr;
  logic [63:0] i_s0_wdata, i_s1_wdata;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [63:0] o_rf_wdata;
  logic [31:0] o_pending;

  always #5 i_clk = ~i_clk;

  rf_wb_arbiter dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_s0_valid (i_s0_valid),
    .o_s0_ready (o_s0_ready),
    .i_s0_waddr (i_s0_waddr),
    .i_s0_wdata (i_s0_wdata),
    .i_s1_valid (i_s1_valid),
    .o_s1_ready (o_s1_ready),
    .i_s1_waddr (i_s1_waddr),
    .i_s1_wdata (i_s1_wdata),
    .o_rf_wen   (o_rf_wen),
    .o_rf_waddr (o_rf_waddr),
    .o_rf_wdata (o_rf_wdata),
    .o_pending  (o_pending)
  );

  int errors = 0;
  int checks = 0;

  // Model: each port holds at most one write; every stored write carries a
  // global sequence number so "older" is simply the smaller number.
  logic        m_v [2];
  logic [4:0]  m_a [2];
  logic [63:0] m_d [2];
  int          m_stamp [2];
  logic        m_rr;
  int          m_seq;

  logic ac0, ac1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    m_rr   = 1'b0;
    m_seq  = 0;
  endtask

  // Drive one cycle of requests, check outputs against the model, advance.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                      output logic acc0, output logic acc1);
    logic        ew, eg, er0, er1;
    logic [31:0] ep;
    logic [4:0]  ea;
    logic [63:0] ed;
    i_s0_valid = v0; i_s0_waddr = a0; i_s0_wdata = d0;
    i_s1_valid = v1; i_s1_waddr = a1; i_s1_wdata = d1;
    #1;
    ew = m_v[0] | m_v[1];
    if (m_v[0] && m_v[1])
      eg = (m_a[0] == m_a[1]) ? (m_stamp[1] < m_stamp[0]) : m_rr;
    else
      eg = m_v[1];
    ea = ew ? m_a[eg] : 5'd0;
    ed = ew ? m_d[eg] : 64'd0;
    ep = '0;
    for (int n = 0; n < 2; n++) if (m_v[n]) ep[m_a[n]] = 1'b1;
    er0 = !m_v[0] || (ew && !eg);
    er1 = !m_v[1] || (ew && eg);
    check("wen",     64'(o_rf_wen),   64'(ew));
    check("waddr",   64'(o_rf_waddr), 64'(ea));
    check("wdata",   o_rf_wdata,      ed);
    check("pending", 64'(o_pending),  64'(ep));
    check("ready0",  64'(o_s0_ready), 64'(er0));
    check("ready1",  64'(o_s1_ready), 64'(er1));
    if (ew) $display("t=%0t write x%0d = %h from port %0d", $time, ea, ed, eg);
    acc0 = v0 & er0;
    acc1 = v1 & er1;
    if (m_v[0] && m_v[1] && (m_a[0] != m_a[1])) m_rr = !eg;
    if (ew) m_v[eg] = 1'b0;
    // LSU stamped first so a same-edge pair makes it the older one.
    if (acc1 && a1 != 5'd0) begin
      m_v[1] = 1'b1; m_a[1] = a1; m_d[1] = d1; m_stamp[1] = m_seq; m_seq++;
    end
    if (acc0 && a0 != 5'd0) begin
      m_v[0] = 1'b1; m_a[0] = a0; m_d[0] = d0; m_stamp[0] = m_seq; m_seq++;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle();
    logic x0, x1;
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, x0, x1);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int i0, i1, cyc;
    logic        p0v, p1v;
    logic [4:0]  p0a, p1a;
    logic [63:0] p0d, p1d;

    i_rst_n = 1'b0;
    i_s0_valid = 1'b0; i_s0_waddr = '0; i_s0_wdata = '0;
    i_s1_valid = 1'b0; i_s1_waddr = '0; i_s1_wdata = '0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check("rst_wen",    64'(o_rf_wen),   64'd0);
    check("rst_waddr",  64'(o_rf_waddr), 64'd0);
    check("rst_wdata",  o_rf_wdata,      64'd0);
    check("rst_pend",   64'(o_pending),  64'd0);
    check("rst_ready0", 64'(o_s0_ready), 64'd1);
    check("rst_ready1", 64'(o_s1_ready), 64'd1);
    i_rst_n = 1'b1;

    // Single write from the EXU.
    step(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0, ac0, ac1);
    check("single_acc",   64'(ac0),        64'd1);
    check("single_wen",   64'(o_rf_wen),   64'd1);
    check("single_addr",  64'(o_rf_waddr), 64'd5);
    check("single_data",  o_rf_wdata,      64'hDEAD);
    check("single_pend",  64'(o_pending),  64'h20);
    idle();
    check("single_clear", 64'(o_pending),  64'd0);

    // x0 request from the LSU is swallowed.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h1234, ac0, ac1);
    check("x0_acc",  64'(ac1),       64'd1);
    check("x0_wen",  64'(o_rf_wen),  64'd0);
    check("x0_pend", 64'(o_pending), 64'd0);
    idle();

    // Round-robin: two streams of distinct destinations.
    i0 = 0; i1 = 0; cyc = 0;
    while ((i0 < 4 || i1 < 4) && cyc < 20) begin
      step(i0 < 4, 5'(1 + i0), 64'(100 + i0), i1 < 4, 5'(11 + i1), 64'(200 + i1), ac0, ac1);
      if (ac0) i0++;
      if (ac1) i1++;
      cyc++;
      if (cyc == 1) check("rr_first_port0", 64'(o_rf_waddr), 64'd1);
    end
    check("rr_done",   64'(i0 + i1), 64'd8);
    check("rr_cycles", 64'(cyc),     64'd7);
    repeat (3) idle();

    // Same-address ordering across separate edges.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hA, ac0, ac1);
    check("age_first",  o_rf_wdata, 64'hA);
    step(1'b1, 5'd7, 64'hB, 1'b0, 5'd0, 64'd0, ac0, ac1);
    check("age_second", o_rf_wdata, 64'hB);
    idle();
    // Same-address pair loaded on one edge: LSU goes first.
    step(1'b1, 5'd9, 64'hC0, 1'b1, 5'd9, 64'hC1, ac0, ac1);
    check("tie_first",  o_rf_wdata, 64'hC1);
    idle();
    check("tie_second", o_rf_wdata, 64'hC0);
    repeat (2) idle();

    // Back-to-back refill of slot 0.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 5'(k), 64'(k * 16), 1'b0, 5'd0, 64'd0, ac0, ac1);
      check("b2b_ready", 64'(ac0), 64'd1);
      check("b2b_wen",   64'(o_rf_wen), 64'd1);
    end
    repeat (2) idle();

    // Randomized traffic; sources hold a request until it is accepted.
    p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p0v && ($urandom_range(0, 9) < 7)) begin
        p0v = 1'b1; p0a = 5'($urandom_range(0, 7)); p0d = rnd64();
      end
      if (!p1v && ($urandom_range(0, 9) < 6)) begin
        p1v = 1'b1; p1a = 5'($urandom_range(0, 7)); p1d = rnd64();
      end
      step(p0v, p0a, p0d, p1v, p1a, p1d, ac0, ac1);
      if (ac0) p0v = 1'b0;
      if (ac1) p1v = 1'b0;
    end
    repeat (3) idle();

    // Reset with both slots full: buffered writes must vanish.
    step(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, ac0, ac1);
    step(1'b1, 5'd5, 64'h55, 1'b1, 5'd6, 64'h66, ac0, ac1);
    check("mid_full", 64'(o_pending != 32'd0), 64'd1);
    i_s0_valid = 1'b0; i_s1_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_wen",    64'(o_rf_wen),   64'd0);
    check("mid_rst_pend",   64'(o_pending),  64'd0);
    check("mid_rst_ready0", 64'(o_s0_ready), 64'd1);
    check("mid_rst_ready1", 64'(o_s1_ready), 64'd1);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
